// File: rtl/oup_ulpi_link_engine.sv
`default_nettype none
// ============================================================================
// Module   : oup_ulpi_link_engine
// Brief    : ULPI sync-mode link engine: TXCMD register access, USB transmit, RX
// Revision : 1.0 - initial release
// ============================================================================
module oup_ulpi_link_engine #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          EXT_REG_EN     = 1'b1
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_ni,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o,
  input  logic [7:0] instruction_i,
  input  logic       exec_i,
  output logic       exec_done_o,
  output logic       exec_aborted_o,
  output logic       busy_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_data_next_o,
  input  logic       tx_data_empty_i,
  output logic [7:0] rx_data_o,
  output logic       rx_data_next_o,
  input  logic       rx_data_full_i,
  output logic       rx_overflow_o,
  output logic [7:0] rx_cmd_byte_o,
  output logic       rx_cmd_valid_o,
  input  logic [7:0] phyreg_i,
  input  logic [7:0] phyreg_addr_i,
  output logic [7:0] phyreg_o,
  output logic [7:0] phyreg_addr_o
);

  localparam logic [1:0]  c_OP_NOP   = 2'b00;
  localparam logic [1:0]  c_OP_TX    = 2'b01;
  localparam logic [1:0]  c_OP_WR    = 2'b10;
  localparam logic [5:0]  c_EXT_ADDR = 6'h2F;
  localparam logic [15:0] c_TIMEOUT  = 16'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CMD     = 4'd1,
    S_EXTADDR = 4'd2,
    S_WDATA   = 4'd3,
    S_STOP    = 4'd4,
    S_RD_TA   = 4'd5,
    S_RD_DATA = 4'd6,
    S_TXDATA  = 4'd7,
    S_ABORT   = 4'd8
  } state_t;

  state_t      r_state;
  logic        r_dir_prev;
  logic [7:0]  r_instr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_ext_addr;
  logic [15:0] r_tmo_cnt;
  logic [7:0]  r_data;
  logic        r_stp;
  logic        r_done;
  logic        r_aborted;
  logic        r_busy;
  logic [7:0]  r_phyreg;
  logic [7:0]  r_phyreg_addr;
  logic [7:0]  r_rx_data;
  logic        r_rx_next;
  logic        r_rx_ovf;
  logic [7:0]  r_rx_cmd;
  logic        r_rx_cmd_valid;

  logic [1:0]  w_opcode;
  logic        w_ext;
  logic        w_turnaround;
  logic        w_waiting;
  logic        w_drive_state;
  logic        w_abort_dir;
  logic        w_expire;
  logic        w_rx_sample;

  assign w_opcode      = r_instr[7:6];
  // Extended addressing only applies to register ops (bit 7 set), never to a transmit PID.
  assign w_ext         = EXT_REG_EN && r_instr[7] && (r_instr[5:0] == c_EXT_ADDR);
  assign w_turnaround  = (ulpi_dir_i != r_dir_prev);
  assign w_drive_state = (r_state == S_CMD) || (r_state == S_EXTADDR) ||
                         (r_state == S_WDATA) || (r_state == S_TXDATA);
  assign w_waiting     = w_drive_state || (r_state == S_RD_TA);
  assign w_abort_dir   = w_drive_state && ulpi_dir_i;
  assign w_expire      = (c_TIMEOUT != 16'd0) && w_waiting && !ulpi_nxt_i &&
                         !ulpi_dir_i && (r_tmo_cnt == c_TIMEOUT);
  assign w_rx_sample   = ulpi_dir_i && !w_turnaround && (r_state != S_RD_DATA);

  // The byte is popped when nxt accepts the TXCMD (loading byte 0) and on each later nxt.
  assign tx_data_next_o = !ulpi_dir_i && ulpi_nxt_i && !tx_data_empty_i &&
                          ((r_state == S_TXDATA) ||
                           ((r_state == S_CMD) && (w_opcode == c_OP_TX)));

  always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_dir_prev    <= 1'b0;
      r_instr       <= 8'h00;
      r_wdata       <= 8'h00;
      r_ext_addr    <= 8'h00;
      r_tmo_cnt     <= 16'd0;
      r_data        <= 8'h00;
      r_stp         <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_busy        <= 1'b0;
      r_phyreg      <= 8'h00;
      r_phyreg_addr <= 8'h00;
    end else begin
      r_dir_prev <= ulpi_dir_i;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_stp      <= 1'b0;
      r_tmo_cnt  <= (!w_waiting || ulpi_nxt_i || ulpi_dir_i || w_expire) ?
                    16'd0 : r_tmo_cnt + 16'd1;

      if (w_abort_dir || w_expire) begin
        r_state   <= S_ABORT;
        r_aborted <= 1'b1;
        r_busy    <= 1'b0;
        r_data    <= 8'h00;
        r_stp     <= w_expire;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (exec_i && !ulpi_dir_i) begin
              r_instr    <= instruction_i;
              r_wdata    <= phyreg_i;
              r_ext_addr <= phyreg_addr_i;
              if (instruction_i[7:6] == c_OP_NOP) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_CMD;
                r_data  <= instruction_i;
                r_busy  <= 1'b1;
              end
            end
          end
          S_CMD: begin
            if (ulpi_nxt_i) begin
              if (w_ext) begin
                r_state <= S_EXTADDR;
                r_data  <= r_ext_addr;
              end else if (w_opcode == c_OP_WR) begin
                r_state <= S_WDATA;
                r_data  <= r_wdata;
              end else if (w_opcode == c_OP_TX) begin
                r_state <= S_TXDATA;
                r_data  <= tx_data_i;
              end else begin
                r_state <= S_RD_TA;
                r_data  <= 8'h00;
              end
            end
          end
          S_EXTADDR: begin
            if (ulpi_nxt_i) begin
              if (w_opcode == c_OP_WR) begin
                r_state <= S_WDATA;
                r_data  <= r_wdata;
              end else begin
                r_state <= S_RD_TA;
                r_data  <= 8'h00;
              end
            end
          end
          S_WDATA: begin
            if (ulpi_nxt_i) begin
              r_state <= S_STOP;
              r_stp   <= 1'b1;
              r_data  <= 8'h00;
            end
          end
          S_STOP: begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
          S_RD_TA: begin
            if (ulpi_dir_i) begin
              r_state <= S_RD_DATA;
            end
          end
          S_RD_DATA: begin
            r_state       <= S_IDLE;
            r_phyreg      <= ulpi_data_i;
            r_phyreg_addr <= w_ext ? r_ext_addr : {2'b00, r_instr[5:0]};
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
          end
          S_TXDATA: begin
            if (ulpi_nxt_i) begin
              if (!tx_data_empty_i) begin
                r_data <= tx_data_i;
              end else begin
                r_state <= S_STOP;
                r_stp   <= 1'b1;
                r_data  <= 8'h00;
              end
            end
          end
          S_ABORT: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_data  <= 8'h00;
          end
        endcase
      end

      if (ulpi_dir_i) begin
        r_data <= 8'h00;
      end
    end
  end

  always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_data      <= 8'h00;
      r_rx_next      <= 1'b0;
      r_rx_ovf       <= 1'b0;
      r_rx_cmd       <= 8'h00;
      r_rx_cmd_valid <= 1'b0;
    end else begin
      r_rx_next      <= 1'b0;
      r_rx_ovf       <= 1'b0;
      r_rx_cmd_valid <= 1'b0;
      if (w_rx_sample) begin
        if (!ulpi_nxt_i) begin
          r_rx_cmd       <= ulpi_data_i;
          r_rx_cmd_valid <= 1'b1;
        end else if (!rx_data_full_i) begin
          r_rx_data <= ulpi_data_i;
          r_rx_next <= 1'b1;
        end else begin
          r_rx_ovf <= 1'b1;
        end
      end
    end
  end

  assign ulpi_data_o    = r_data;
  assign ulpi_stp_o     = r_stp;
  assign exec_done_o    = r_done;
  assign exec_aborted_o = r_aborted;
  assign busy_o         = r_busy;
  assign rx_data_o      = r_rx_data;
  assign rx_data_next_o = r_rx_next;
  assign rx_overflow_o  = r_rx_ovf;
  assign rx_cmd_byte_o  = r_rx_cmd;
  assign rx_cmd_valid_o = r_rx_cmd_valid;
  assign phyreg_o       = r_phyreg;
  assign phyreg_addr_o  = r_phyreg_addr;

endmodule
`default_nettype wire

// File: tb/tb_oup_ulpi_link_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_oup_ulpi_link_engine
// Brief    : Directed-vector bench for oup_ulpi_link_engine
// Revision : 1.0 - initial release
// ============================================================================
module tb_oup_ulpi_link_engine;

  logic       ulpi_clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] ulpi_data_i = 8'h00;
  logic       ulpi_dir_i = 1'b0;
  logic       ulpi_nxt_i = 1'b0;
  logic [7:0] instruction_i = 8'h00;
  logic       exec_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_data_empty_i = 1'b1;
  logic       rx_data_full_i = 1'b0;
  logic [7:0] phyreg_i = 8'h00;
  logic [7:0] phyreg_addr_i = 8'h00;

  logic [7:0] ulpi_data_o;
  logic       ulpi_stp_o;
  logic       exec_done_o;
  logic       exec_aborted_o;
  logic       busy_o;
  logic       tx_data_next_o;
  logic [7:0] rx_data_o;
  logic       rx_data_next_o;
  logic       rx_overflow_o;
  logic [7:0] rx_cmd_byte_o;
  logic       rx_cmd_valid_o;
  logic [7:0] phyreg_o;
  logic [7:0] phyreg_addr_o;

  always #5 ulpi_clk_i = ~ulpi_clk_i;

  oup_ulpi_link_engine #(
    .TIMEOUT_CYCLES(4),
    .EXT_REG_EN    (1'b1)
  ) dut (
    .ulpi_clk_i     (ulpi_clk_i),
    .rst_ni         (rst_ni),
    .ulpi_data_i    (ulpi_data_i),
    .ulpi_data_o    (ulpi_data_o),
    .ulpi_dir_i     (ulpi_dir_i),
    .ulpi_nxt_i     (ulpi_nxt_i),
    .ulpi_stp_o     (ulpi_stp_o),
    .instruction_i  (instruction_i),
    .exec_i         (exec_i),
    .exec_done_o    (exec_done_o),
    .exec_aborted_o (exec_aborted_o),
    .busy_o         (busy_o),
    .tx_data_i      (tx_data_i),
    .tx_data_next_o (tx_data_next_o),
    .tx_data_empty_i(tx_data_empty_i),
    .rx_data_o      (rx_data_o),
    .rx_data_next_o (rx_data_next_o),
    .rx_data_full_i (rx_data_full_i),
    .rx_overflow_o  (rx_overflow_o),
    .rx_cmd_byte_o  (rx_cmd_byte_o),
    .rx_cmd_valid_o (rx_cmd_valid_o),
    .phyreg_i       (phyreg_i),
    .phyreg_addr_i  (phyreg_addr_i),
    .phyreg_o       (phyreg_o),
    .phyreg_addr_o  (phyreg_addr_o)
  );

  int n_vec = 0;
  int n_miss = 0;
  int pop_cnt = 0;
  int rxn_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] tx_fifo [0:2];
  int tx_len = 0;
  int tx_idx = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic update_tx();
    tx_data_empty_i = (tx_idx >= tx_len);
    tx_data_i       = tx_data_empty_i ? 8'h00 : tx_fifo[tx_idx];
  endtask

  // Advance one clock; the transmit source model pops on tx_data_next_o at the edge.
  task automatic tick();
    logic pop;
    #1;
    pop = tx_data_next_o;
    pop_cnt += int'(pop);
    @(posedge ulpi_clk_i);
    #1;
    if (pop) tx_idx++;
    update_tx();
    rxn_cnt += int'(rx_data_next_o);
    ovf_cnt += int'(rx_overflow_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("reset_outputs",
          {ulpi_data_o, ulpi_stp_o, exec_done_o, exec_aborted_o, busy_o,
           rx_data_next_o, rx_overflow_o, rx_cmd_valid_o, phyreg_o, phyreg_addr_o},
          64'h0);
    rst_ni = 1'b1;
    tick();

    // no-op instruction
    instruction_i = 8'h00; exec_i = 1'b1;
    tick();
    exec_i = 1'b0;
    check("nop_done", {exec_done_o, busy_o, ulpi_data_o}, {1'b1, 1'b0, 8'h00});
    tick();
    check("nop_done_clear", exec_done_o, 1'b0);

    // immediate write 84 / 55 with nxt held high
    instruction_i = 8'h84; phyreg_i = 8'h55; ulpi_nxt_i = 1'b1; exec_i = 1'b1;
    tick();
    exec_i = 1'b0;
    check("wr_cmd_byte", {busy_o, ulpi_data_o}, {1'b1, 8'h84});
    tick();
    check("wr_data_byte", ulpi_data_o, 8'h55);
    tick();
    check("wr_stp", {ulpi_stp_o, ulpi_data_o, exec_done_o}, {1'b1, 8'h00, 1'b0});
    tick();
    check("wr_done", {exec_done_o, ulpi_stp_o, busy_o}, {1'b1, 1'b0, 1'b0});
    ulpi_nxt_i = 1'b0;
    tick();

    // extended read EF, address 3A, PHY returns C3
    instruction_i = 8'hEF; phyreg_addr_i = 8'h3A; ulpi_nxt_i = 1'b1; exec_i = 1'b1;
    tick();
    exec_i = 1'b0;
    check("rd_cmd_byte", ulpi_data_o, 8'hEF);
    tick();
    check("rd_ext_addr", ulpi_data_o, 8'h3A);
    tick();
    ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b0; ulpi_data_i = 8'hFF;
    tick();
    check("rd_turnaround_quiet", {rx_cmd_valid_o, exec_done_o}, 2'b00);
    ulpi_data_i = 8'hC3;
    tick();
    check("rd_result", {exec_done_o, phyreg_o, phyreg_addr_o, rx_cmd_valid_o},
          {1'b1, 8'hC3, 8'h3A, 1'b0});
    ulpi_dir_i = 1'b0; ulpi_data_i = 8'h00;
    tick();

    // transmit PID 43 with payload 11 22 33, nxt 1,0,1,1,1
    tx_fifo[0] = 8'h11; tx_fifo[1] = 8'h22; tx_fifo[2] = 8'h33;
    tx_len = 3; tx_idx = 0; update_tx(); pop_cnt = 0;
    instruction_i = 8'h43; exec_i = 1'b1;
    tick();
    exec_i = 1'b0;
    check("tx_cmd_byte", ulpi_data_o, 8'h43);
    ulpi_nxt_i = 1'b1;
    tick();
    check("tx_byte0", ulpi_data_o, 8'h11);
    ulpi_nxt_i = 1'b0;
    tick();
    check("tx_byte0_hold", ulpi_data_o, 8'h11);
    ulpi_nxt_i = 1'b1;
    tick();
    check("tx_byte1", ulpi_data_o, 8'h22);
    tick();
    check("tx_byte2", ulpi_data_o, 8'h33);
    tick();
    check("tx_stp", {ulpi_stp_o, ulpi_data_o}, {1'b1, 8'h00});
    ulpi_nxt_i = 1'b0;
    tick();
    check("tx_done", {exec_done_o, ulpi_stp_o}, 2'b10);
    check("tx_pop_count", pop_cnt, 3);

    // abort: dir rises during WDATA, then RX CMD 0E
    instruction_i = 8'h84; phyreg_i = 8'h55; ulpi_nxt_i = 1'b1; exec_i = 1'b1;
    tick();
    exec_i = 1'b0;
    tick();
    check("ab_wdata", ulpi_data_o, 8'h55);
    ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b0;
    tick();
    check("ab_pulse", {exec_aborted_o, ulpi_stp_o, busy_o}, {1'b1, 1'b0, 1'b0});
    ulpi_data_i = 8'h0E;
    tick();
    check("ab_rxcmd", {exec_aborted_o, ulpi_stp_o, rx_cmd_valid_o, rx_cmd_byte_o},
          {1'b0, 1'b0, 1'b1, 8'h0E});
    ulpi_dir_i = 1'b0; ulpi_data_i = 8'h00;
    tick();
    check("ab_rxcmd_held", {rx_cmd_valid_o, rx_cmd_byte_o}, {1'b0, 8'h0E});

    // timeout with TIMEOUT_CYCLES = 4 and nxt never asserted
    instruction_i = 8'h84; exec_i = 1'b1;
    tick();
    exec_i = 1'b0;
    repeat (4) tick();
    check("to_not_yet", {ulpi_stp_o, exec_aborted_o}, 2'b00);
    tick();
    check("to_abort", {ulpi_stp_o, exec_aborted_o, ulpi_data_o}, {1'b1, 1'b1, 8'h00});
    tick();
    check("to_after", {ulpi_stp_o, exec_aborted_o, busy_o}, 3'b000);

    // RX data with the sink full on byte 3; exec ignored while dir is high
    ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b0;
    tick();
    rxn_cnt = 0; ovf_cnt = 0;
    ulpi_nxt_i = 1'b1; ulpi_data_i = 8'hA1; instruction_i = 8'h84; exec_i = 1'b1;
    tick();
    exec_i = 1'b0;
    check("rx_byte1", {rx_data_next_o, rx_data_o, busy_o}, {1'b1, 8'hA1, 1'b0});
    ulpi_data_i = 8'hA2;
    tick();
    ulpi_data_i = 8'hA3; rx_data_full_i = 1'b1;
    tick();
    check("rx_overflow", {rx_overflow_o, rx_data_next_o, rx_data_o}, {1'b1, 1'b0, 8'hA2});
    ulpi_data_i = 8'hA4; rx_data_full_i = 1'b0;
    tick();
    check("rx_push_count", rxn_cnt, 3);
    check("rx_ovf_count", ovf_cnt, 1);
    ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b0; ulpi_data_i = 8'h00;
    tick();

    // asynchronous reset in the middle of a transmit
    tx_idx = 0; update_tx();
    instruction_i = 8'h43; ulpi_nxt_i = 1'b1; exec_i = 1'b1;
    tick();
    exec_i = 1'b0;
    tick();
    check("rst_pre_busy", busy_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_outputs",
          {ulpi_data_o, ulpi_stp_o, exec_done_o, exec_aborted_o, busy_o, tx_data_next_o,
           phyreg_o, phyreg_addr_o, rx_cmd_byte_o, rx_data_o, rx_cmd_valid_o},
          64'h0);
    ulpi_nxt_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    check("rst_release_quiet", {ulpi_stp_o, exec_aborted_o, busy_o}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
